mips_inst_encoder: RTL and testbench

Instruction encoder and loader: the inverse of the opcode decoder in the control path. It accepts symbolic instructions (mnemonic plus register, immediate and target fields) over a valid/ready handshake. Each one is packed into a 32-bit MIPS word using the same opcode/funct map the control unit decodes, then written sequentially into instruction memory through a write/ack interface. It is used for program preload and for self-test images.

---
 rtl/mips_isa_pkg.sv | 68 ++++++
 rtl/mips_inst_pack.sv | 64 ++++++
 rtl/mips_inst_encoder.sv | 162 ++++++++++++++++
 tb/tb_mips_inst_encoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and future disassembler checks:
// opcodes, funct codes, mnemonic select codes, encoder FSM states and field packers.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] MN_ADD  = 5'd0;
  localparam logic [4:0] MN_SUB  = 5'd1;
  localparam logic [4:0] MN_AND  = 5'd2;
  localparam logic [4:0] MN_OR   = 5'd3;
  localparam logic [4:0] MN_SLT  = 5'd4;
  localparam logic [4:0] MN_SLL  = 5'd5;
  localparam logic [4:0] MN_SRL  = 5'd6;
  localparam logic [4:0] MN_JR   = 5'd7;
  localparam logic [4:0] MN_LW   = 5'd8;
  localparam logic [4:0] MN_SW   = 5'd9;
  localparam logic [4:0] MN_ADDI = 5'd10;
  localparam logic [4:0] MN_ANDI = 5'd11;
  localparam logic [4:0] MN_ORI  = 5'd12;
  localparam logic [4:0] MN_SLTI = 5'd13;
  localparam logic [4:0] MN_XORI = 5'd14;
  localparam logic [4:0] MN_BEQ  = 5'd15;
  localparam logic [4:0] MN_BNE  = 5'd16;
  localparam logic [4:0] MN_J    = 5'd17;
  localparam logic [4:0] MN_JAL  = 5'd18;
  localparam logic [4:0] MN_LUI  = 5'd19;
  localparam logic [4:0] MN_NOP  = 5'd20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_inst_pack.sv
// Combinational packer: mnemonic plus operand fields -> 32-bit MIPS word, with
// illegal-mnemonic and control-transfer (branch/jump) flags.
module mips_inst_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnemonic,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal,
  output logic        is_ctrl
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    is_ctrl = 1'b0;
    case (mnemonic)
      MN_ADD:  word = r_word(rs, rt, rd, shamt, FN_ADD);
      MN_SUB:  word = r_word(rs, rt, rd, shamt, FN_SUB);
      MN_AND:  word = r_word(rs, rt, rd, shamt, FN_AND);
      MN_OR:   word = r_word(rs, rt, rd, shamt, FN_OR);
      MN_SLT:  word = r_word(rs, rt, rd, shamt, FN_SLT);
      // Shifts take their source from rt, so the rs slot is architecturally zero.
      MN_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      MN_SRL:  word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      MN_JR: begin
        word    = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
        is_ctrl = 1'b1;
      end
      MN_LW:   word = i_word(OP_LW, rs, rt, imm);
      MN_SW:   word = i_word(OP_SW, rs, rt, imm);
      MN_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      MN_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
      MN_ORI:  word = i_word(OP_ORI, rs, rt, imm);
      MN_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
      MN_XORI: word = i_word(OP_XORI, rs, rt, imm);
      MN_BEQ: begin
        word    = i_word(OP_BEQ, rs, rt, imm);
        is_ctrl = 1'b1;
      end
      MN_BNE: begin
        word    = i_word(OP_BNE, rs, rt, imm);
        is_ctrl = 1'b1;
      end
      MN_J: begin
        word    = {OP_J, target};
        is_ctrl = 1'b1;
      end
      MN_JAL: begin
        word    = {OP_JAL, target};
        is_ctrl = 1'b1;
      end
      MN_LUI:  word = i_word(OP_LUI, 5'd0, rt, imm);
      MN_NOP:  word = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_inst_encoder.sv
// Instruction encoder/loader: packs symbolic instructions and writes them sequentially
// into instruction memory. Define DELAY_SLOT_NOP_EN to append a NOP after every branch/jump.
module mips_inst_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnemonic,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_ack,
  output logic              busy,
  output logic              full,
  output logic              illegal,
  output logic [ADDR_W:0]   count
);

`ifdef DELAY_SLOT_NOP_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_t              state, state_nxt;
  logic [ADDR_W:0]     count_nxt, cnt_inc;
  logic                illegal_nxt, full_nxt, fin_pend, fin_nxt, slot_pend, slot_nxt;
  logic                wr_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [31:0]         data_nxt;
  logic [31:0]         pk_word;
  logic                pk_illegal, pk_ctrl, handshake;

  mips_inst_pack u_pack (
    .mnemonic (mnemonic),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .imm      (imm),
    .target   (target),
    .word     (pk_word),
    .illegal  (pk_illegal),
    .is_ctrl  (pk_ctrl)
  );

  assign in_ready  = (state == ST_ACCEPT);
  assign busy      = (state != ST_IDLE);
  assign handshake = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      illegal   <= 1'b0;
      full      <= 1'b0;
      fin_pend  <= 1'b0;
      slot_pend <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      illegal   <= illegal_nxt;
      full      <= full_nxt;
      fin_pend  <= fin_nxt;
      slot_pend <= slot_nxt;
      mem_write <= wr_nxt;
      mem_addr  <= addr_nxt;
      mem_data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    illegal_nxt = illegal;
    full_nxt    = full;
    fin_nxt     = fin_pend;
    slot_nxt    = slot_pend;
    wr_nxt      = mem_write;
    addr_nxt    = mem_addr;
    data_nxt    = mem_data;
    cnt_inc     = count + (ADDR_W+1)'(1);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_ACCEPT;
          count_nxt   = '0;
          illegal_nxt = 1'b0;
          full_nxt    = 1'b0;
          fin_nxt     = 1'b0;
          slot_nxt    = 1'b0;
        end
      end
      ST_ACCEPT: begin
        if (handshake) begin
          if (pk_illegal) begin
            illegal_nxt = 1'b1;
            if (finish) state_nxt = ST_IDLE;
          end else begin
            wr_nxt    = 1'b1;
            addr_nxt  = BASE_C + count[ADDR_W-1:0];
            data_nxt  = pk_word;
            slot_nxt  = SLOT_EN && pk_ctrl;
            fin_nxt   = finish;
            state_nxt = ST_WRITE;
          end
        end else if (finish) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (finish) fin_nxt = 1'b1;
        if (mem_ack) begin
          count_nxt = cnt_inc;
          wr_nxt    = 1'b0;
          if (cnt_inc == DEPTH_C) begin
            // A full memory wins over both the delay-slot NOP and a pending finish.
            state_nxt = ST_FULL;
            full_nxt  = 1'b1;
            slot_nxt  = 1'b0;
            fin_nxt   = 1'b0;
          end else if (slot_pend) begin
            slot_nxt = 1'b0;
            wr_nxt   = 1'b1;
            addr_nxt = BASE_C + cnt_inc[ADDR_W-1:0];
            data_nxt = '0;
          end else if (fin_pend || finish) begin
            state_nxt = ST_IDLE;
            fin_nxt   = 1'b0;
          end else begin
            state_nxt = ST_ACCEPT;
          end
        end
      end
      ST_FULL: begin
        if (finish) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Self-checking bench for mips_inst_encoder: directed scenarios plus randomized
// instructions checked against an arithmetic reference encoder.
module tb_mips_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0, mem_ack = 1'b0;
  logic [4:0]  mnemonic = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        in_ready, mem_write, busy, full, illegal;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [8:0]  count;

  logic        s_start = 1'b0, s_finish = 1'b0, s_valid = 1'b0, s_ack = 1'b0;
  logic        s_in_ready, s_mem_write, s_busy, s_full, s_illegal;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_data;
  logic [2:0]  s_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_count = 0;
  logic [31:0] last_data;
  logic [7:0]  last_addr;

  always #5 clk = ~clk;

  mips_inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .in_valid(in_valid),
    .in_ready(in_ready), .mnemonic(mnemonic), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .busy(busy), .full(full), .illegal(illegal),
    .count(count)
  );

  mips_inst_encoder #(.ADDR_W(2), .BASE_ADDR(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .finish(s_finish), .in_valid(s_valid),
    .in_ready(s_in_ready), .mnemonic(mnemonic), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
    .mem_data(s_mem_data), .mem_ack(s_ack), .busy(s_busy), .full(s_full),
    .illegal(s_illegal), .count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder built from the field layout with plain arithmetic.
  function automatic void ref_enc(input int mn, output logic [31:0] w,
                                  output bit ctrl, output bit ill);
    int rfn[8] = '{32, 34, 36, 37, 42, 0, 2, 8};
    int iop[9] = '{35, 43, 8, 12, 13, 10, 14, 4, 5};
    longint s, t, d, h, v;
    s = rs; t = rt; d = rd; h = shamt;
    ctrl = 0; ill = 0; v = 0;
    if (mn <= 7) begin
      if (mn == 5 || mn == 6) s = 0;
      if (mn == 7) begin t = 0; d = 0; h = 0; ctrl = 1; end
      v = s * 2097152 + t * 65536 + d * 2048 + h * 64 + rfn[mn];
    end else if (mn <= 16) begin
      v = longint'(iop[mn-8]) * 67108864 + s * 2097152 + t * 65536 + imm;
      ctrl = (mn == 15 || mn == 16);
    end else if (mn == 17 || mn == 18) begin
      v = longint'(mn - 15) * 67108864 + target;
      ctrl = 1;
    end else if (mn == 19) begin
      v = 15 * 67108864 + t * 65536 + imm;
    end else if (mn == 20) begin
      v = 0;
    end else begin
      ill = 1;
    end
    w = v[31:0];
  endfunction

  task automatic write_word(input logic [31:0] w, input int dly, input bit fin);
    logic [7:0] ea;
    ea = 8'(exp_count);
    chk("wr_req", 32'(mem_write), 32'd1);
    chk("wr_addr", 32'(mem_addr), 32'(ea));
    chk("wr_data", mem_data, w);
    chk("wr_ready", 32'(in_ready), 32'd0);
    last_data = mem_data;
    last_addr = mem_addr;
    for (int i = 0; i < dly; i++) begin
      if (fin && i == 0) finish = 1'b1;
      step();
      finish = 1'b0;
      chk("hold_req", 32'(mem_write), 32'd1);
      chk("hold_addr", 32'(mem_addr), 32'(ea));
      chk("hold_data", mem_data, w);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    exp_count++;
  endtask

  task automatic send(input int mn, input int dly, input bit fin);
    logic [31:0] w;
    bit ctrl, ill;
    ref_enc(mn, w, ctrl, ill);
    chk("acc_ready", 32'(in_ready), 32'd1);
    mnemonic = 5'(mn);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (ill) begin
      chk("ill_nowrite", 32'(mem_write), 32'd0);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_count", 32'(count), 32'(exp_count));
      chk("ill_ready", 32'(in_ready), 32'd1);
      return;
    end
    write_word(w, dly, fin);
`ifdef DELAY_SLOT_NOP_EN
    if (ctrl) write_word(32'h0, 0, 1'b0);
`endif
    chk("post_count", 32'(count), 32'(exp_count));
    chk("post_wr", 32'(mem_write), 32'd0);
    if (fin) chk("post_busy", 32'(busy), 32'd0);
    else     chk("post_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic open_session();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_count = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_count", 32'(count), 32'd0);
  endtask

  task automatic close_session();
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("close_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wr", 32'(mem_write), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_s_busy", 32'(s_busy), 32'd0);
    rst_n = 1'b1;
    step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("idle_finish_ignored", 32'(busy), 32'd0);

    // Plan 1: ADD with immediate ack.
    open_session();
    rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0;
    send(0, 0, 1'b0);
    chk("t1_data", last_data, 32'h00221820);
    chk("t1_addr", 32'(last_addr), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    close_session();

    // Plan 2: LW then SW.
    open_session();
    rs = 5'd29; rt = 5'd8; imm = 16'h0004;
    send(8, 1, 1'b0);
    chk("t2_lw", last_data, 32'h8FA80004);
    send(9, 0, 1'b0);
    chk("t2_sw", last_data, 32'hAFA80004);
    chk("t2_sw_addr", 32'(last_addr), 32'd1);
    close_session();

    // Plan 3: JAL, with or without the delay-slot NOP.
    open_session();
    target = 26'h10;
    send(18, 0, 1'b0);
`ifdef DELAY_SLOT_NOP_EN
    chk("t3_nop", last_data, 32'h0);
    chk("t3_count", 32'(count), 32'd2);
`else
    chk("t3_jal", last_data, 32'h0C000010);
    chk("t3_count", 32'(count), 32'd1);
`endif
    close_session();

    // Plan 4: ack withheld five cycles, finish raised during the write.
    open_session();
    rs = 5'd4; rt = 5'd5; rd = 5'd6;
    send(0, 5, 1'b1);

    // Plan 6a: illegal mnemonic consumed without a write.
    open_session();
    send(31, 0, 1'b0);
    send(1, 0, 1'b0);
    chk("t6_ill_sticky", 32'(illegal), 32'd1);
    close_session();

    // Randomized instructions against the reference encoder.
    open_session();
    chk("rand_ill_clear", 32'(illegal), 32'd0);
    for (int k = 0; k < 40; k++) begin
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
      imm = 16'($urandom); target = 26'($urandom);
      send(int'($urandom_range(0, 23)), int'($urandom_range(0, 3)), 1'b0);
    end
    close_session();

    // Plan 5: four-word memory with base 1 wraps and fills.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mnemonic = 5'd20;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      chk("s_wr", 32'(s_mem_write), 32'd1);
      chk("s_addr", 32'(s_mem_addr), 32'((1 + i) % 4));
      chk("s_data", s_mem_data, 32'd0);
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
    end
    chk("s_full", 32'(s_full), 32'd1);
    chk("s_ready", 32'(s_in_ready), 32'd0);
    chk("s_count", 32'(s_count), 32'd4);
    chk("s_wr_done", 32'(s_mem_write), 32'd0);
    s_finish = 1'b1;
    step();
    s_finish = 1'b0;
    chk("s_idle", 32'(s_busy), 32'd0);
    chk("s_full_held", 32'(s_full), 32'd1);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("s_full_clr", 32'(s_full), 32'd0);

    // Plan 6b: async reset in the middle of a write.
    open_session();
    send(31, 0, 1'b0);
    mnemonic = 5'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("r_wr_before", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r_wr", 32'(mem_write), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_ill", 32'(illegal), 32'd0);
    chk("r_count", 32'(count), 32'd0);
    chk("r_data", mem_data, 32'd0);
    chk("r_s_busy", 32'(s_busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
